// File: rtl/clock_divider_mc_if.sv
// Control/output bundle for clock_divider_mc: per-channel load/stop/mode
// strobes in, tick and mode-dependent outputs back.
interface clock_divider_mc_if #(
  parameter int p_CHANNELS = 4,
  parameter int p_WIDTH    = 32
);
  logic                  i_sync;
  logic [p_CHANNELS-1:0] i_load;
  logic [p_WIDTH-1:0]    i_div;
  logic [p_CHANNELS-1:0] i_stop;
  logic [p_CHANNELS-1:0] i_mode;
  logic [p_CHANNELS-1:0] o_tick;
  logic [p_CHANNELS-1:0] o_out;

  modport master (output i_sync, i_load, i_div, i_stop, i_mode,
                  input  o_tick, o_out);
  modport slave  (input  i_sync, i_load, i_div, i_stop, i_mode,
                  output o_tick, o_out);
endinterface

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable divider / tick generator with per-channel stop and load.
// Define CLOCK_DIV_SQUARE_EN to add the 50% square output selected by i_mode.
module clock_divider_mc_ch #(
  parameter int          p_WIDTH       = 32,
  parameter int unsigned p_DEFAULT_DIV = 50000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sync,
  input  logic               i_load,
  input  logic [p_WIDTH-1:0] i_div,
  input  logic               i_stop,
  input  logic               i_mode,
  output logic               o_tick,
  output logic               o_out
);
  localparam logic [p_WIDTH-1:0] DEF_DIV = p_WIDTH'(p_DEFAULT_DIV);

  typedef enum logic [1:0] {RUN = 2'b00, STOP = 2'b01, WRAP = 2'b10} state_t;

  state_t             state;
  logic [p_WIDTH-1:0] div_reg;
  logic [p_WIDTH-1:0] cnt;
  logic [p_WIDTH-1:0] term;
  logic               at_term;

  // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign term    = (div_reg == '0) ? '0 : div_reg - 1'b1;
  assign at_term = (cnt == term);

  // Leaving STOP evaluates the terminal count on the same edge, so a stop
  // that lands on D-1 only stretches the period and never drops the tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= RUN;
      div_reg <= DEF_DIV;
      cnt     <= '0;
    end else if (i_sync) begin
      state <= i_stop ? STOP : RUN;
      cnt   <= '0;
    end else if (i_load) begin
      div_reg <= i_div;
      cnt     <= '0;
      state   <= i_stop ? STOP : RUN;
    end else if (i_stop) begin
      state <= STOP;
    end else if (at_term) begin
      state <= WRAP;
      cnt   <= '0;
    end else begin
      state <= RUN;
      cnt   <= cnt + 1'b1;
    end
  end

  // The WRAP state lasts exactly one cycle per period and is the tick.
  assign o_tick = (state == WRAP);

`ifdef CLOCK_DIV_SQUARE_EN
  logic sq;
  logic mode_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sq     <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      mode_q <= i_mode;
      if (i_sync)
        sq <= 1'b0;
      else if (!i_load && !i_stop && at_term)
        sq <= ~sq;
    end
  end

  assign o_out = mode_q ? sq : o_tick;
`else
  logic unused_mode;
  assign unused_mode = i_mode;
  assign o_out       = o_tick;
`endif
endmodule

module clock_divider_mc #(
  parameter int          p_CHANNELS    = 4,
  parameter int          p_WIDTH       = 32,
  parameter int unsigned p_DEFAULT_DIV = 50000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  clock_divider_mc_if.slave bus
);
  logic [p_CHANNELS-1:0] tick;
  logic [p_CHANNELS-1:0] out;

  for (genvar c = 0; c < p_CHANNELS; c++) begin : g_ch
    clock_divider_mc_ch #(
      .p_WIDTH       (p_WIDTH),
      .p_DEFAULT_DIV (p_DEFAULT_DIV)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sync (bus.i_sync),
      .i_load (bus.i_load[c]),
      .i_div  (bus.i_div),
      .i_stop (bus.i_stop[c]),
      .i_mode (bus.i_mode[c]),
      .o_tick (tick[c]),
      .o_out  (out[c])
    );
  end

  assign bus.o_tick = tick;
  assign bus.o_out  = out;
endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed bench for clock_divider_mc (2 channels, 8-bit, default divisor 5)
// with a countdown model checked every cycle plus hand-computed edge checks.
module tb_clock_divider_mc;
  localparam int C   = 2;
  localparam int W   = 8;
  localparam int DEF = 5;

  logic i_clk;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  clock_divider_mc_if #(.p_CHANNELS(C), .p_WIDTH(W)) bus ();

  clock_divider_mc #(.p_CHANNELS(C), .p_WIDTH(W), .p_DEFAULT_DIV(DEF)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Model: cycles remaining until the next tick, decremented on each running edge.
  int           m_rem  [C];
  logic [W-1:0] m_div  [C];
  logic         m_sq   [C];
  logic         m_tick [C];
  logic         m_out  [C];

  function automatic int eff(input logic [W-1:0] d);
    return (d == '0) ? 1 : int'(d);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_n, act, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < C; c++) begin
      if (i_rst) begin
        m_div[c] = W'(DEF); m_rem[c] = DEF; m_sq[c] = 1'b0; m_tick[c] = 1'b0;
      end else if (bus.i_sync) begin
        m_rem[c] = eff(m_div[c]); m_sq[c] = 1'b0; m_tick[c] = 1'b0;
      end else if (bus.i_load[c]) begin
        m_div[c] = bus.i_div; m_rem[c] = eff(m_div[c]); m_tick[c] = 1'b0;
      end else if (bus.i_stop[c]) begin
        m_tick[c] = 1'b0;
      end else begin
        m_rem[c] = m_rem[c] - 1;
        m_tick[c] = (m_rem[c] == 0);
        if (m_tick[c]) begin
          m_sq[c]  = ~m_sq[c];
          m_rem[c] = eff(m_div[c]);
        end
      end
`ifdef CLOCK_DIV_SQUARE_EN
      m_out[c] = i_rst ? 1'b0 : (bus.i_mode[c] ? m_sq[c] : m_tick[c]);
`else
      m_out[c] = i_rst ? 1'b0 : m_tick[c];
`endif
    end
    edge_n = i_rst ? 0 : edge_n + 1;
  endtask

  // One clock: update model on the edge, compare 1 time unit later.
  task automatic cyc();
    @(posedge i_clk);
    model_step();
    #1;
    for (int c = 0; c < C; c++) begin
      chk($sformatf("model_tick%0d", c), bus.o_tick[c], m_tick[c]);
      chk($sformatf("model_out%0d", c),  bus.o_out[c],  m_out[c]);
    end
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (edge_n < n && guard < 1000) begin
      cyc();
      guard++;
    end
    checks++;
    if (edge_n != n) begin
      errors++;
      $display("FAIL run_to: reached edge %0d expected %0d", edge_n, n);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    bus.i_sync = 1'b0; bus.i_load = '0; bus.i_stop = '0; bus.i_div = '0;
    cyc();
    cyc();
    chk("rst_tick0", bus.o_tick[0], 1'b0);
    chk("rst_out1",  bus.o_out[1],  1'b0);
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    bus.i_sync = 1'b0; bus.i_load = '0; bus.i_stop = '0; bus.i_div = '0; bus.i_mode = '0;

    // Reset release: pulse every 5 on ch0, square on ch1.
    bus.i_mode = 2'b10;
    do_reset();
    run_to(4);  chk("s1_tick0_e4", bus.o_tick[0], 1'b0);
    run_to(5);  chk("s1_tick0_e5", bus.o_tick[0], 1'b1);
                chk("s1_out0_e5",  bus.o_out[0],  1'b1);
                chk("s1_out1_e5",  bus.o_out[1],  1'b1);
    run_to(6);  chk("s1_tick0_e6", bus.o_tick[0], 1'b0);
`ifdef CLOCK_DIV_SQUARE_EN
                chk("s1_out1_e6",  bus.o_out[1],  1'b1);
    run_to(10); chk("s1_out1_e10", bus.o_out[1],  1'b0);
`else
                chk("s1_out1_e6",  bus.o_out[1],  1'b0);
    run_to(10); chk("s1_out1_e10", bus.o_out[1],  1'b1);
`endif
                chk("s1_tick0_e10", bus.o_tick[0], 1'b1);
    run_to(15); chk("s1_tick0_e15", bus.o_tick[0], 1'b1);

    // Stop ch0 on edges 5..7 while cnt sits at terminal count.
    bus.i_mode = 2'b00;
    do_reset();
    run_to(4); bus.i_stop = 2'b01;
    run_to(5); chk("s2_tick0_e5", bus.o_tick[0], 1'b0);
               chk("s2_tick1_e5", bus.o_tick[1], 1'b1);
    run_to(7); bus.i_stop = 2'b00;
    run_to(8);  chk("s2_tick0_e8",  bus.o_tick[0], 1'b1);
    run_to(12); chk("s2_tick0_e12", bus.o_tick[0], 1'b0);
    run_to(13); chk("s2_tick0_e13", bus.o_tick[0], 1'b1);

    // Load ch1 with 0 at edge 7, then with 3 at edge 11.
    do_reset();
    run_to(6); bus.i_load = 2'b10; bus.i_div = 8'd0;
    run_to(7); bus.i_load = 2'b00;
    run_to(8);  chk("s3_tick1_e8",  bus.o_tick[1], 1'b1);
    run_to(9);  chk("s3_tick1_e9",  bus.o_tick[1], 1'b1);
    run_to(10); chk("s3_tick1_e10", bus.o_tick[1], 1'b1);
    bus.i_load = 2'b10; bus.i_div = 8'd3;
    run_to(11); bus.i_load = 2'b00;
    run_to(12); chk("s3_tick1_e12", bus.o_tick[1], 1'b0);
    run_to(13); chk("s3_tick1_e13", bus.o_tick[1], 1'b0);
    run_to(14); chk("s3_tick1_e14", bus.o_tick[1], 1'b1);
    run_to(17); chk("s3_tick1_e17", bus.o_tick[1], 1'b1);

    // Out-of-phase channels realigned by sync at edge 20.
    bus.i_mode = 2'b11;
    do_reset();
    run_to(1); bus.i_load = 2'b01; bus.i_div = 8'd3;
    run_to(2); bus.i_load = 2'b00;
    run_to(19); bus.i_sync = 1'b1;
    run_to(20); bus.i_sync = 1'b0;
    chk("s4_out0_e20", bus.o_out[0], 1'b0);
    chk("s4_out1_e20", bus.o_out[1], 1'b0);
    run_to(23); chk("s4_tick0_e23", bus.o_tick[0], 1'b1);
                chk("s4_tick1_e23", bus.o_tick[1], 1'b0);
                chk("s4_out0_e23",  bus.o_out[0],  1'b1);
    run_to(25); chk("s4_tick1_e25", bus.o_tick[1], 1'b1);

    // Reset mid-period with stop and load active.
    bus.i_mode = 2'b01;
    do_reset();
    run_to(3);
    i_rst = 1'b1; bus.i_stop = 2'b11; bus.i_load = 2'b11; bus.i_div = 8'd2;
    cyc();
    chk("s5_tick0", bus.o_tick[0], 1'b0);
    chk("s5_out0",  bus.o_out[0],  1'b0);
    chk("s5_tick1", bus.o_tick[1], 1'b0);
    i_rst = 1'b0; bus.i_stop = 2'b00; bus.i_load = 2'b00;
    run_to(4); chk("s5_tick0_e4", bus.o_tick[0], 1'b0);
    run_to(5); chk("s5_tick0_e5", bus.o_tick[0], 1'b1);
               chk("s5_tick1_e5", bus.o_tick[1], 1'b1);

    // Mixed random control traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.i_stop = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      bus.i_load = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      bus.i_div  = W'($urandom_range(0, 7));
      bus.i_sync = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) bus.i_mode = 2'($urandom_range(0, 3));
      i_rst = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
